// File: rtl/spi_reg_ctrl.sv
// spi_reg_ctrl: SPI mode-0 slave register file for audio routing control and status interrupts.
`timescale 1ns/1ps
module spi_reg_ctrl #(
    parameter logic [7:0] ID_VALUE    = 8'hA1,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       CLK,
    input  logic       nRESET,
    input  logic       SCLK,
    input  logic       nSS,
    input  logic       MOSI,
    output logic       MISO,
    output logic       MISO_OE,
    input  logic       EMPH,
    input  logic       ERROR,
    input  logic       nOVFL,
    output logic [1:0] SRC_SEL,
    output logic       DAC_MUTE,
    output logic       INT
);
    typedef enum logic [1:0] {IDLE, CMD, DATA} state_t;
    // bit order {nOVFL, ERROR, EMPH, MOSI, nSS, SCLK}; idle levels avoid spurious edges after reset
    localparam logic [5:0] SYNC_RST = 6'b100010;
    logic [SYNC_STAGES-1:0][5:0] sq;
    logic [5:0] s;
    logic [4:0] s_d;
    logic sclk_rise, sclk_fall, nss_fall, nss_s;
    logic [2:0] irq_set, irq_clr;
    state_t state, state_n;
    logic [2:0] bit_cnt;
    logic [7:0] rx, rx_n, tx, rd_data;
    logic [6:0] addr, wr_addr, rd_addr;
    logic [2:0] wr_data, ctrl, mask, flags;
    logic rw, wr_pend, int_q;

    assign s         = sq[SYNC_STAGES-1];
    assign nss_s     = s[1];
    assign sclk_rise = s[0] & ~s_d[0];
    assign sclk_fall = ~s[0] & s_d[0];
    assign nss_fall  = ~s[1] & s_d[1];
    assign irq_set   = {s[3] ^ s_d[2], ~s[5] & s_d[4], s[4] & ~s_d[3]};
    assign irq_clr   = (wr_pend && wr_addr == 7'h03) ? wr_data : 3'b000;
    assign rx_n      = {rx[6:0], s[2]};
    assign rd_addr   = (state == CMD) ? rx_n[6:0] : addr + 7'd1;
    assign MISO      = (state == DATA) && rw && tx[7];
    assign MISO_OE   = ~nss_s;
    assign SRC_SEL   = ctrl[1:0];
    assign DAC_MUTE  = ctrl[2];
    assign INT       = int_q;

    always_comb begin
        rd_data = rd_addr == 7'h00 ? ID_VALUE :
                  rd_addr == 7'h01 ? {5'b0, ctrl} :
                  rd_addr == 7'h02 ? {5'b0, ~s[5], s[4], s[3]} :
                  rd_addr == 7'h03 ? {5'b0, flags} :
                  rd_addr == 7'h04 ? {5'b0, mask} : 8'h00;
    end

    always_comb begin
        state_n = nss_s                                          ? IDLE :
                  (state == IDLE && nss_fall)                    ? CMD  :
                  (state == CMD && sclk_rise && bit_cnt == 3'd7) ? DATA : state;
    end

    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) state <= IDLE;
        else         state <= state_n;
    end

    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            sq      <= {SYNC_STAGES{SYNC_RST}};
            s_d     <= {SYNC_RST[5:3], SYNC_RST[1:0]};
            bit_cnt <= '0;
            rx      <= '0;
            tx      <= '0;
            rw      <= 1'b0;
            addr    <= '0;
            wr_pend <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
            ctrl    <= '0;
            mask    <= '0;
            flags   <= '0;
            int_q   <= 1'b0;
        end else begin
            sq      <= {sq[SYNC_STAGES-2:0], {nOVFL, ERROR, EMPH, MOSI, nSS, SCLK}};
            s_d     <= {s[5:3], s[1:0]};
            wr_pend <= 1'b0;
            if (state == IDLE) begin
                bit_cnt <= '0;
                rx      <= '0;
            end else if (!nss_s && sclk_rise) begin
                rx      <= rx_n;
                bit_cnt <= bit_cnt + 3'd1;
                if (bit_cnt == 3'd7 && state == CMD) begin
                    rw   <= rx_n[7];
                    addr <= rx_n[6:0];
                    tx   <= rd_data;
                end else if (bit_cnt == 3'd7) begin
                    if (rw) tx <= rd_data;
                    wr_pend <= ~rw;
                    wr_addr <= addr;
                    wr_data <= rx_n[2:0];
                    addr    <= addr + 7'd1;
                end
            // the fall right after a byte boundary must keep bit 7 on MISO for the next rise
            end else if (!nss_s && sclk_fall && state == DATA && bit_cnt != 3'd0) begin
                tx <= {tx[6:0], 1'b0};
            end
            if (wr_pend && wr_addr == 7'h01) ctrl <= wr_data;
            if (wr_pend && wr_addr == 7'h04) mask <= wr_data;
            flags <= (flags & ~irq_clr) | irq_set;
            int_q <= |(flags & mask);
        end
    end
endmodule

// File: doc/spi_reg_ctrl.md
Name: spi_reg_ctrl

Overview:
- SPI slave register controller, clocked from the MCU oscillator domain.
- Decodes MCU SPI transactions (mode 0, MSB first) into a small register file.
- Drives audio routing configuration: SPDIF coax/toslink select, ADC select, DAC mute.
- Collects SPDIF receiver and ADC status into sticky interrupt flags and drives INT to the MCU.

Parameters:
- ID_VALUE, 8'hA1, read-only value returned at address 0x00.
- SYNC_STAGES, 2, synchronizer depth for SCLK, nSS, MOSI, EMPH, ERROR, nOVFL (min 2).

Ports:
- CLK  in  1  system clock (MCU_OSC).
- nRESET  in  1  reset; asynchronous assert, active-low.
- SCLK  in  1  SPI clock, async to CLK.
- nSS  in  1  SPI select, active-low.
- MOSI  in  1  SPI data in.
- MISO  out  1  SPI data out.
- MISO_OE  out  1  MISO drive enable = ~nSS_sync.
- EMPH  in  1  SPDIF receiver emphasis flag.
- ERROR  in  1  SPDIF receiver error flag.
- nOVFL  in  1  ADC overflow, active-low.
- SRC_SEL  out  2  0 coax SPDIF, 1 toslink SPDIF, 2 ADC, 3 none.
- DAC_MUTE  out  1  DAC mute request.
- INT  out  1  interrupt to MCU, active-high, registered.

Behaviour:
- Reset values: all outputs 0; CTRL=0x00; IRQ_MASK=0x00; IRQ_FLAGS=0x00; FSM=IDLE.
- Synchronization: all async inputs pass SYNC_STAGES flops. Edge detect on synced SCLK (rise/fall) and nSS (fall).
- Edge detect adds 1 further cycle, so SCLK high and low phases must each be >= SYNC_STAGES+2 CLK cycles.
- Register map:
  - 0x00 ID: RO, returns ID_VALUE.
  - 0x01 CTRL: RW; [1:0] SRC_SEL, [2] DAC_MUTE, [7:3] read 0.
  - 0x02 STATUS: RO live; [0] EMPH, [1] ERROR, [2] ~nOVFL.
  - 0x03 IRQ_FLAGS: write-1-to-clear; [0] ERROR rising, [1] nOVFL falling, [2] EMPH toggled.
  - 0x04 IRQ_MASK: RW, [2:0].
  - Other addresses: read 0x00, writes ignored.
- Frame format: command byte, then data bytes.
  - Command byte: [7] 1 = read, 0 = write; [6:0] address.
  - Each following data byte uses current address, then address increments (7-bit wrap 0x7F -> 0x00).
- FSM states:
  - IDLE: nSS falling -> CMD, bit count = 0, rx shift = 0.
  - CMD: shift MOSI into rx shift on each SCLK rise. On the 8th bit, latch rw and addr, then -> DATA.
    - If read: load tx shift with reg[addr]; MISO = tx[7] in the same cycle.
  - DATA: shift MOSI on each SCLK rise; shift tx left on each SCLK fall.
    - On the 8th rise, write: commit rx byte to reg[addr] in the next CLK cycle.
    - On the 8th rise, read: reload tx with reg[addr+1].
    - Then addr++; stay in DATA.
  - Any state: nSS high (synced) -> IDLE.
    - Partial byte discarded; no write commits.
    - MISO = 0.
- MISO is 0 during the command byte and in IDLE.
- Interrupts:
  - Flag set on the synced input event.
  - Hardware set and W1C clear in the same cycle: set wins.
  - INT = |(IRQ_FLAGS & IRQ_MASK), registered, 1-cycle latency.
- Read of IRQ_FLAGS does not clear.
- CTRL write takes effect on SRC_SEL/DAC_MUTE the cycle after commit.
- SCLK edges while nSS is high are ignored.

Test Plan:
- Write: nSS low, send 0x01 then 0x06, nSS high -> SRC_SEL=2'b10, DAC_MUTE=1; MISO=0 throughout.
- Read ID: send 0x80 then 0x00 -> MISO returns 0xA1 MSB first.
- Burst read from CTRL (after setting CTRL=0x02), send 0x81, 0x00, 0x00 -> bytes returned 0x02, then STATUS.
- Abort: send 0x01 plus 4 data bits, nSS high -> CTRL unchanged; next frame decodes correctly from bit 0.
- IRQ, steps in order:
  - IRQ_MASK=0x01; pulse ERROR -> INT=1 within SYNC_STAGES+2 cycles; read 0x03 returns 0x01.
  - Write 0x03=0x01 -> INT=0.
  - ERROR rising in the same cycle as the clear -> flag remains 1.
- Async reset mid-frame (after 3 bits) -> all outputs 0 immediately; CTRL=0; next full frame works.
